// File: rtl/demux_1ton_reg.sv
// Registered 1-to-N demultiplexer: steers each input word to the output channel chosen by sel.
// Latency: 1 cycle from input transfer to out_valid/out_data; err_sel/drop_cnt also 1 cycle.
// Backpressure: in_ready drops only when the selected channel is full and not draining, or en=0.
module demux_1ton_reg #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned N_OUT     = 4,
    parameter int unsigned SEL_W     = 2,
    parameter int unsigned ZERO_IDLE = 0,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [SEL_W-1:0]       sel,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic                   err_sel,
    output logic [CNT_W-1:0]       drop_cnt
);

    // N_OUT always fits in SEL_W+1 bits because 2**SEL_W >= N_OUT.
    localparam logic [SEL_W:0] N_OUT_W = (SEL_W+1)'(N_OUT);

    // Channel i is slice [i] of the packed array, which lines up with out_data[i*WIDTH +: WIDTH].
    logic [N_OUT-1:0][WIDTH-1:0] data_q;
    logic [N_OUT-1:0]            valid_q;
    logic                        err_q;
    logic [CNT_W-1:0]            drop_q;

    logic [N_OUT-1:0] sel_dec;
    logic [N_OUT-1:0] load;
    logic [N_OUT-1:0] drain;
    logic             sel_bad;
    logic             sel_busy;
    logic             xfer;

    // Decode sel; an out-of-range sel decodes to no channel, so it can never stall the input.
    always_comb begin
        sel_dec = '0;
        for (int i = 0; i < N_OUT; i++) begin
            sel_dec[i] = ({1'b0, sel} == (SEL_W+1)'(i));
        end
    end

    assign sel_bad  = ({1'b0, sel} >= N_OUT_W);
    assign drain    = valid_q & out_ready;
    // Selected channel is busy only if it holds a word that is not leaving this cycle.
    assign sel_busy = |(sel_dec & valid_q & ~out_ready);
    assign in_ready = en && !sel_busy;
    assign xfer     = in_valid && in_ready;
    assign load     = xfer ? sel_dec : '0;

    // Per-channel holding registers: a load wins over a drain so a draining channel refills in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (load[i]) begin
                    valid_q[i] <= 1'b1;
                    data_q[i]  <= in_data;
                end else if (drain[i]) begin
                    valid_q[i] <= 1'b0;
                    if (ZERO_IDLE != 0) begin
                        data_q[i] <= '0;
                    end
                end
            end
        end
    end

    // Words addressed past the last channel are swallowed, flagged for one cycle and counted (saturating).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            err_q <= xfer && sel_bad;
            if (xfer && sel_bad && !(&drop_q)) begin
                drop_q <= drop_q + CNT_W'(1);
            end
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign err_sel   = err_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_demux_1ton_reg.sv
// Bench for demux_1ton_reg: two instances (4 channels keep-last, 3 channels zero-idle with a 2-bit counter).
// Stimulus pushes expected words per channel; a negedge monitor pops them as each channel drains.
// Directed checks cover reset, routing, backpressure, replace, invalid sel, enable and reset mid-stream.
module tb_demux_1ton_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance A: N_OUT=4, ZERO_IDLE=0, CNT_W=8
    logic        a_en;
    logic [1:0]  a_sel;
    logic [7:0]  a_in_data;
    logic        a_in_valid;
    logic        a_in_ready;
    logic [31:0] a_out_data;
    logic [3:0]  a_out_valid;
    logic [3:0]  a_out_ready;
    logic        a_err_sel;
    logic [7:0]  a_drop_cnt;

    // Instance B: N_OUT=3, ZERO_IDLE=1, CNT_W=2
    logic        b_en;
    logic [1:0]  b_sel;
    logic [7:0]  b_in_data;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [23:0] b_out_data;
    logic [2:0]  b_out_valid;
    logic [2:0]  b_out_ready;
    logic        b_err_sel;
    logic [1:0]  b_drop_cnt;

    demux_1ton_reg #(.WIDTH(8), .N_OUT(4), .SEL_W(2), .ZERO_IDLE(0), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(a_en), .sel(a_sel), .in_data(a_in_data),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .err_sel(a_err_sel),
        .drop_cnt(a_drop_cnt)
    );

    demux_1ton_reg #(.WIDTH(8), .N_OUT(3), .SEL_W(2), .ZERO_IDLE(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(b_en), .sel(b_sel), .in_data(b_in_data),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .err_sel(b_err_sel),
        .drop_cnt(b_drop_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_a [4][$];
    logic [7:0] exp_b [3][$];
    logic [1:0] exp_err_b [$];
    logic [1:0] b_drop_model;
    logic [7:0] prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic note_unexpected(input string name, input logic [31:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got unexpected output 0x%0h, required none", name, act);
    endtask

    // Scoreboard monitor: every word leaving a channel must match the oldest expected word for it.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (a_out_valid[i] && a_out_ready[i]) begin
                    if (exp_a[i].size() == 0) note_unexpected($sformatf("a_ch%0d_word", i), {24'd0, a_out_data[i*8 +: 8]});
                    else chk($sformatf("a_ch%0d_word", i), {24'd0, a_out_data[i*8 +: 8]}, {24'd0, exp_a[i].pop_front()});
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (b_out_valid[i] && b_out_ready[i]) begin
                    if (exp_b[i].size() == 0) note_unexpected($sformatf("b_ch%0d_word", i), {24'd0, b_out_data[i*8 +: 8]});
                    else chk($sformatf("b_ch%0d_word", i), {24'd0, b_out_data[i*8 +: 8]}, {24'd0, exp_b[i].pop_front()});
                end
            end
            if (b_err_sel) begin
                if (exp_err_b.size() == 0) note_unexpected("b_err_pulse", {30'd0, b_drop_cnt});
                else chk("b_err_drop_cnt", {30'd0, b_drop_cnt}, {30'd0, exp_err_b.pop_front()});
            end
            if (a_err_sel) note_unexpected("a_err_pulse", {24'd0, a_drop_cnt});
        end
    end

    task automatic a_send(input logic [1:0] s, input logic [7:0] d);
        bit ok = 1'b0;
        a_sel = s; a_in_data = d; a_in_valid = 1'b1;
        for (int k = 0; k < 16 && !ok; k++) begin
            @(negedge clk);
            if (a_in_ready) ok = 1'b1;
        end
        if (ok) begin
            exp_a[s].push_back(d);
            @(posedge clk); #1;
        end else begin
            n_tests++; n_fail++;
            $display("FAIL a_send_timeout: in_ready stayed 0, required 1");
        end
        a_in_valid = 1'b0;
    endtask

    task automatic b_send(input logic [1:0] s, input logic [7:0] d);
        bit ok = 1'b0;
        b_sel = s; b_in_data = d; b_in_valid = 1'b1;
        for (int k = 0; k < 16 && !ok; k++) begin
            @(negedge clk);
            if (b_in_ready) ok = 1'b1;
        end
        if (ok) begin
            if (s < 2'd3) exp_b[s].push_back(d);
            @(posedge clk); #1;
        end else begin
            n_tests++; n_fail++;
            $display("FAIL b_send_timeout: in_ready stayed 0, required 1");
        end
        b_in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // One invalid-sel word per cycle for n cycles on instance B; the model saturates at 3.
    task automatic b_drops(input int n);
        b_sel = 2'd3; b_in_data = 8'hFF; b_in_valid = 1'b1;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            chk("inv_in_ready", {31'd0, b_in_ready}, 32'd1);
            if (b_drop_model != 2'd3) b_drop_model = b_drop_model + 2'd1;
            exp_err_b.push_back(b_drop_model);
            tick();
        end
        b_in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_en = 1'b0; a_sel = '0; a_in_data = '0; a_in_valid = 1'b0; a_out_ready = '0;
        b_en = 1'b0; b_sel = '0; b_in_data = '0; b_in_valid = 1'b0; b_out_ready = '0;
        b_drop_model = '0;
        prev = '0;

        // Reset state
        @(negedge clk);
        chk("rst_a_valid", {28'd0, a_out_valid}, 32'd0);
        chk("rst_a_data", a_out_data, 32'd0);
        chk("rst_a_drop", {24'd0, a_drop_cnt}, 32'd0);
        chk("rst_b_valid", {29'd0, b_out_valid}, 32'd0);
        chk("rst_b_err", {31'd0, b_err_sel}, 32'd0);
        chk("rst_b_drop", {30'd0, b_drop_cnt}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic routing: 0xA5 to channel 2 with all consumers ready
        a_en = 1'b1; a_out_ready = 4'b1111;
        a_sel = 2'd2; a_in_data = 8'hA5; a_in_valid = 1'b1;
        @(negedge clk);
        chk("basic_in_ready", {31'd0, a_in_ready}, 32'd1);
        exp_a[2].push_back(8'hA5);
        tick();
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("basic_valid_1", {28'd0, a_out_valid}, 32'h4);
        chk("basic_slice2_1", {24'd0, a_out_data[23:16]}, 32'hA5);
        @(negedge clk);
        chk("basic_valid_2", {28'd0, a_out_valid}, 32'h0);
        chk("basic_slice2_2", {24'd0, a_out_data[23:16]}, 32'hA5);

        // Backpressure isolation
        tick();
        a_out_ready = 4'b0000;
        a_sel = 2'd1; a_in_data = 8'h11; a_in_valid = 1'b1;
        @(negedge clk);
        chk("bp_accept_11", {31'd0, a_in_ready}, 32'd1);
        exp_a[1].push_back(8'h11);
        tick();
        a_in_data = 8'h22;
        @(negedge clk);
        chk("bp_block_22_a", {31'd0, a_in_ready}, 32'd0);
        tick();
        @(negedge clk);
        chk("bp_block_22_b", {31'd0, a_in_ready}, 32'd0);
        tick();
        a_sel = 2'd3; a_in_data = 8'h33;
        @(negedge clk);
        chk("bp_accept_33", {31'd0, a_in_ready}, 32'd1);
        exp_a[3].push_back(8'h33);
        tick();
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("bp_valid", {28'd0, a_out_valid}, 32'hA);
        tick();
        a_out_ready = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        chk("bp_drained", {28'd0, a_out_valid}, 32'h0);

        // Full-throughput replace on channel 0
        tick();
        a_out_ready = 4'b0000;
        a_send(2'd0, 8'h5A);
        a_out_ready = 4'b0001;
        a_sel = 2'd0; a_in_valid = 1'b1;
        prev = 8'h5A;
        for (int j = 1; j <= 3; j++) begin
            a_in_data = j[7:0];
            @(negedge clk);
            chk("rep_in_ready", {31'd0, a_in_ready}, 32'd1);
            chk("rep_valid0", {31'd0, a_out_valid[0]}, 32'd1);
            chk("rep_slice0", {24'd0, a_out_data[7:0]}, {24'd0, prev});
            exp_a[0].push_back(j[7:0]);
            prev = j[7:0];
            tick();
        end
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("rep_valid0_last", {31'd0, a_out_valid[0]}, 32'd1);
        chk("rep_slice0_last", {24'd0, a_out_data[7:0]}, 32'h03);
        tick();
        a_out_ready = 4'b0000;
        @(negedge clk);
        chk("rep_drained", {28'd0, a_out_valid}, 32'h0);

        // Invalid sel on the 3-channel instance, channel 0 held
        tick();
        b_en = 1'b1; b_out_ready = 3'b000;
        b_send(2'd0, 8'h77);
        b_drops(3);
        @(negedge clk);
        chk("inv_drop_cnt_3", {30'd0, b_drop_cnt}, 32'd3);
        chk("inv_valid_kept", {29'd0, b_out_valid}, 32'h1);
        @(negedge clk);
        chk("inv_err_low", {31'd0, b_err_sel}, 32'd0);
        tick();
        b_drops(2);
        @(negedge clk);
        @(negedge clk);
        chk("inv_drop_sat", {30'd0, b_drop_cnt}, 32'd3);
        chk("inv_valid_kept2", {29'd0, b_out_valid}, 32'h1);

        // Enable low and zero-idle drain on channel 1
        tick();
        b_send(2'd1, 8'h9C);
        @(negedge clk);
        chk("en_valid_full", {29'd0, b_out_valid}, 32'h3);
        tick();
        b_en = 1'b0; b_sel = 2'd1; b_in_data = 8'h44; b_in_valid = 1'b1;
        @(negedge clk);
        chk("en0_ready_sel1", {31'd0, b_in_ready}, 32'd0);
        tick();
        b_sel = 2'd2;
        @(negedge clk);
        chk("en0_ready_sel2", {31'd0, b_in_ready}, 32'd0);
        tick();
        b_out_ready = 3'b010;
        @(negedge clk);
        chk("en0_ready_drain", {31'd0, b_in_ready}, 32'd0);
        tick();
        @(negedge clk);
        chk("en0_valid_after", {29'd0, b_out_valid}, 32'h1);
        chk("en0_slice1_zero", {24'd0, b_out_data[15:8]}, 32'h0);
        tick();
        b_in_valid = 1'b0; b_en = 1'b1; b_out_ready = 3'b111;
        @(negedge clk);
        @(negedge clk);
        chk("zi_all_empty", {29'd0, b_out_valid}, 32'h0);
        chk("zi_all_zero", {8'd0, b_out_data}, 32'h0);

        // Reset mid-stream with channels 0 and 2 of instance A full
        tick();
        b_out_ready = 3'b000;
        a_out_ready = 4'b0000;
        a_send(2'd0, 8'hC0);
        a_send(2'd2, 8'hC2);
        @(negedge clk);
        chk("mid_valid_full", {28'd0, a_out_valid}, 32'h5);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_a_valid", {28'd0, a_out_valid}, 32'h0);
        chk("mid_rst_a_data", a_out_data, 32'h0);
        chk("mid_rst_b_drop", {30'd0, b_drop_cnt}, 32'd0);
        for (int i = 0; i < 4; i++) exp_a[i].delete();
        for (int i = 0; i < 3; i++) exp_b[i].delete();
        exp_err_b.delete();
        b_drop_model = '0;
        a_sel = 2'd0; a_in_data = 8'hEE; a_in_valid = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", {31'd0, a_in_ready}, 32'd1);
        tick();
        a_in_valid = 1'b0;
        a_out_ready = 4'b1111;
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("post_rst_valid", {28'd0, a_out_valid}, 32'h0);
        end
        tick();
        a_send(2'd1, 8'h3C);
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_drained", {28'd0, a_out_valid}, 32'h0);

        // Every expected word and error pulse must have been seen
        for (int i = 0; i < 4; i++) chk($sformatf("a_ch%0d_left", i), exp_a[i].size(), 32'd0);
        for (int i = 0; i < 3; i++) chk($sformatf("b_ch%0d_left", i), exp_b[i].size(), 32'd0);
        chk("b_err_left", exp_err_b.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
